// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: 16-bit sample buffer between the ADC capture sequencer
// and the readout path. Words go in on fifo_write and come back in order on
// fifo_read. fifo_init arms the block and walks a zero-fill over the memory.
// Optional build macro: ADC_FIFO_BYTE_SEL_EN masks unselected byte lanes of
// wr_data to 0x00 before they are stored.
module adc_sample_fifo #(
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_init,
  input  logic              fifo_write,
  input  logic              fifo_read,
  input  logic [1:0]        wr_byte_sel,
  input  logic [15:0]       wr_data,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int LEVEL_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, CLEAR, ACTIVE} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] clr_cnt;
  logic [15:0]       mem [DEPTH];
  logic [15:0]       wr_word;
  logic              wr_acc;
  logic              rd_acc;
  logic              clr_last;

`ifdef ADC_FIFO_BYTE_SEL_EN
  assign wr_word = {wr_byte_sel[1] ? wr_data[15:8] : 8'h00,
                    wr_byte_sel[0] ? wr_data[7:0]  : 8'h00};
`else
  logic [1:0] unused_byte_sel;
  assign unused_byte_sel = wr_byte_sel;
  assign wr_word         = wr_data;
`endif

  // Occupancy flags are decoded from the registered level, so they move one
  // cycle after the strobe edge together with level itself.
  assign empty    = (level == '0);
  assign full     = (level == LEVEL_W'(DEPTH));
  assign busy     = (state == CLEAR);
  assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));

  // fifo_init wins over any strobe in the same cycle, so it blocks acceptance.
  // A write into a full buffer still fits when a read frees a slot this cycle.
  assign rd_acc = (state == ACTIVE) && fifo_read && !fifo_init && !empty;
  assign wr_acc = (state == ACTIVE) && fifo_write && !fifo_init && (!full || rd_acc);

  // State register; reset always drops back to IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: init (re)starts a clear from any state, the clear
  // finishes after the last address has been zeroed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fifo_init) state_next = CLEAR;
      CLEAR:   begin
                 if (fifo_init)     state_next = CLEAR;
                 else if (clr_last) state_next = ACTIVE;
               end
      ACTIVE:  if (fifo_init) state_next = CLEAR;
      default: state_next = IDLE;
    endcase
  end

  // Pointers, level, read port and sticky flags. Init zeroes the bookkeeping
  // and the clear counter; refused strobes (outside init cycles) latch flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      clr_cnt   <= '0;
      level     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr];
      if (fifo_init) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        clr_cnt   <= '0;
        level     <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (state == CLEAR)           clr_cnt   <= clr_cnt + ADDR_W'(1);
        if (wr_acc)                   wr_ptr    <= wr_ptr + ADDR_W'(1);
        if (rd_acc)                   rd_ptr    <= rd_ptr + ADDR_W'(1);
        level <= level + LEVEL_W'(wr_acc) - LEVEL_W'(rd_acc);
        if (fifo_write && !wr_acc)    overflow  <= 1'b1;
        if (fifo_read && !rd_acc)     underflow <= 1'b1;
      end
    end
  end

  // Sample memory: zero-filled one address per cycle during CLEAR, otherwise
  // written at wr_ptr on accepted writes. Contents are not reset.
  always_ff @(posedge clk) begin
    if (state == CLEAR)  mem[clr_cnt] <= 16'h0000;
    else if (wr_acc)     mem[wr_ptr]  <= wr_word;
  end

endmodule

// File: doc/adc_sample_fifo.md
# adc_sample_fifo

Sample buffer on the receiving end of the ADC capture strobe interface. Accepts 16-bit ADC words on `fifo_write` strobes and returns them in order on `fifo_read` strobes. `fifo_init` arms the block and runs a memory clear. The buffer sits between the capture sequencer and the SDRAM/readout path and reports occupancy and sticky error flags.

## Interface
- `DEPTH`, 256, number of 16-bit entries; power of two, ≥4.
- `ADDR_W`, $clog2(DEPTH), pointer width; derived, not to be overridden.
- `clk` in 1: clock; all logic on the rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `fifo_init` in 1: arm/clear request, one-cycle strobe.
- `fifo_write` in 1: write strobe; one word per cycle while high.
- `fifo_read` in 1: read strobe; one word per cycle while high.
- `wr_byte_sel` in 2: byte-lane enables for `wr_data` (bit1 = [15:8], bit0 = [7:0]).
- `wr_data` in 16: write word.
- `rd_data` out 16: read word, registered.
- `rd_valid` out 1: `rd_data` valid, one-cycle pulse per accepted read.
- `busy` out 1: clear in progress.
- `empty` out 1: level == 0.
- `full` out 1: level == DEPTH.
- `level` out ADDR_W+1: stored word count, 0..DEPTH.
- `overflow` out 1: sticky; a write was dropped.
- `underflow` out 1: sticky; a read was refused.

## Operation
- States are IDLE, CLEAR and ACTIVE. Reset enters IDLE.
- IDLE:
  - Writes are dropped and set `overflow`.
  - Reads are refused and set `underflow`.
  - `fifo_init` moves the block to CLEAR.
- CLEAR:
  - A clear counter walks addresses 0..DEPTH-1, writing 0x0000 at one address per cycle.
  - Pointers, `level`, `overflow` and `underflow` are zeroed on entry.
  - Writes and reads are treated as in IDLE.
  - `fifo_init` during CLEAR restarts the counter at 0.
  - After address DEPTH-1 the block moves to ACTIVE.
- ACTIVE:
  - Write accepted when `!full`, or when `full` and a read is accepted in the same cycle. Data goes to `mem[wr_ptr]` and `wr_ptr` increments.
  - Read accepted when `!empty`. `rd_data <= mem[rd_ptr]` and `rd_ptr` increments. A word written in the same cycle as an empty-read is not returned by that read.
  - `level <= level + wr_acc - rd_acc`. Pointers wrap modulo DEPTH.
  - A refused write sets `overflow`; a refused read sets `underflow`. Flags clear only on reset or on CLEAR entry.
  - `fifo_init` moves the block to CLEAR and discards stored data.
- `fifo_init` has priority over simultaneous `fifo_write`/`fifo_read`. Strobes in that cycle are dropped and do not set the flags.

## Timing
- Reset values:
  - State IDLE.
  - `rd_data` = 0x0000, `rd_valid` = 0, `busy` = 0.
  - `empty` = 1, `full` = 0, `level` = 0.
  - `overflow` = 0, `underflow` = 0.
  - Pointers and clear counter = 0.
- Reset mid-CLEAR or mid-ACTIVE aborts immediately to the reset values above. Memory contents are not guaranteed.
- `busy` goes high the cycle after `fifo_init` and stays high for exactly DEPTH cycles.
- The first write is accepted on the cycle `busy` is low after CLEAR.
- Read latency is 1 cycle: a strobe at edge N gives `rd_data`/`rd_valid` after edge N+1. `rd_valid` is 0 on cycles with no accepted read; `rd_data` holds its last value.
- `level`, `empty`, `full` and the flags are registered and update one cycle after the strobe edge.
- Write-to-read: a word written at edge N is readable by a strobe at edge N+1.

## Configuration
- `ADC_FIFO_BYTE_SEL_EN` defined:
  - A lane with a 0 bit in `wr_byte_sel` is stored as 0x00.
  - `wr_byte_sel` = 2'b00 still consumes an entry, storing 0x0000.
- `ADC_FIFO_BYTE_SEL_EN` undefined: `wr_byte_sel` is ignored and the full 16-bit word is stored.

## Test plan
- Reset, then write 0x1234 without init → dropped; `overflow` = 1, `level` = 0. Then `fifo_init` → `busy` high for 256 cycles, `overflow` = 0.
- After CLEAR, write 129 words 0x0000..0x0080, then 129 reads → `rd_data` returns 0x0000..0x0080 in order, each 1 cycle after its strobe; final `empty` = 1, `level` = 0.
- Fill 256 words → `full` = 1. A 257th write alone → dropped, `overflow` = 1. Write+read in the same cycle while full → both accepted, `level` stays 256.
- Read while empty → `underflow` = 1, no `rd_valid`. Simultaneous write 0xBEEF + read on empty → read refused, `level` = 1, next read returns 0xBEEF.
- `fifo_init` at clear address 100 → counter restarts; `busy` stays high 256 more cycles. `reset_n` low mid-ACTIVE → all outputs at reset values next cycle.
- With `ADC_FIFO_BYTE_SEL_EN`: write 0xABCD with `wr_byte_sel` = 2'b01 → read returns 0x00CD. Without the macro → read returns 0xABCD.
